mem_wb_skid_stage: RTL and testbench
====================================

# mem_wb_skid_stage

Parametrised MEM→WB pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and a saturating stall counter. It replaces the fixed-width, always-capturing MEM/WB latch. Backpressure from write-back (for example, a multi-cycle HI/LO write) now stalls the memory stage without losing data. A flush drops in-flight instructions as bubbles with all control bits cleared.

## Interface
- `DATA_W`, default 160: packed data payload (ALU result, read data, HI, LO, zero word = 5×32).
- `CTRL_W`, default 10: packed control payload (write address [3:0], RegWrite, MoveNotZero, DontMove, HiOrLo, MemToReg, HiLoToReg).
- `CNT_W`, default 16: width of the stall counter.
- Clock and reset: a single clock `Clk`, with a synchronous, active-high reset `Rst`. Every register updates on the rising edge of `Clk`.
- `Clk`, input, 1 bit: clock.
- `Rst`, input, 1 bit: synchronous, active-high reset.
- `InValid`, input, 1 bit: the MEM stage presents an entry.
- `InReady`, output, 1 bit: the stage can accept an entry this cycle.
- `InCtrl`, input, `CTRL_W` bits: incoming control.
- `InData`, input, `DATA_W` bits: incoming data.
- `Flush`, input, 1 bit: discard all held entries and the incoming entry.
- `OutValid`, output, 1 bit: an entry is presented to WB.
- `OutReady`, input, 1 bit: WB consumes the entry this cycle.
- `OutCtrl`, output, `CTRL_W` bits: held control. It is forced to 0 when `OutValid` = 0.
- `OutData`, output, `DATA_W` bits: held data. It keeps its last value when `OutValid` = 0.
- `StallCount`, output, `CNT_W` bits: saturating count of cycles with `OutValid` & ~`OutReady`.

## Operation
- Storage: a main entry M (drives `Out*`) and a skid entry S. Occupancy is tracked by the state machine:
  - EMPTY = 0
  - ONE = 1 (M valid)
  - FULL = 2 (M and S valid)
- Handshake signals:
  - `InReady` = (state != FULL) & ~`Rst`. It is decoded from registered state only and has no combinational path from `OutReady`.
  - `OutValid` = (state != EMPTY).
  - push = `InValid` & `InReady`.
  - pop = `OutValid` & `OutReady`.
- Transitions when `Flush` = 0:
  - EMPTY: push → ONE, with In written to M.
  - ONE, push & pop → ONE, with In written to M.
  - ONE, push & ~pop → FULL, with In written to S.
  - ONE, pop only → EMPTY.
  - FULL: pop → ONE, with S moved to M. Push is impossible in FULL.
- Ordering is strictly FIFO: M is always older than S.
- Flush behaviour:
  - `Flush` = 1 → EMPTY on the next edge, regardless of push or pop.
  - The incoming entry is dropped even though `InReady` was 1.
  - A pop in the same cycle still counts as consumed by WB.
- `StallCount` behaviour:
  - Increments by 1 on each edge where `OutValid` & ~`OutReady`.
  - Saturates at 2^`CNT_W`−1.
  - Is unaffected by `Flush`.
  - Is cleared only by `Rst`.
- Payloads are opaque. The stage never inspects `InData`. `InCtrl` is only stored, and is masked to 0 on the output when the stage is invalid.

## Timing
- Reset values, with `Rst` sampled high at an edge: state EMPTY, M = 0, S = 0, `StallCount` = 0. Therefore `OutValid` = 0, `OutCtrl` = 0, `OutData` = 0, and `InReady` = 0 while `Rst` is high.
- `InReady` = 1 in the first cycle after `Rst` falls.
- Reset mid-operation discards all entries. `Rst` takes priority over `Flush`.
- Latency: an entry pushed at edge k is visible on `Out*` after edge k, provided the stage was EMPTY, or was ONE with a pop at k.
- Throughput is 1 entry per cycle with `OutReady` held high.
- Backpressure:
  - After `OutReady` falls, at most one more entry is accepted (into S).
  - `InReady` drops in the cycle after that acceptance.
- Release from FULL: when `OutReady` rises, the S entry appears on `Out*` after one edge, and `InReady` returns to 1 in the same cycle.
- Push and pop in the same cycle are legal in ONE.
- Push and flush in the same cycle: flush wins.

## Structure
- Shared package `mem_wb_pkg` holds:
  - State encodings `ST_EMPTY` = 2'd0, `ST_ONE` = 2'd1, `ST_FULL` = 2'd2.
  - Control bit indices: `CTRL_WADDR` [3:0], `CTRL_REGWRITE` = 4, `CTRL_MOVNZ` = 5, `CTRL_DONTMOVE` = 6, `CTRL_HIORLO` = 7, `CTRL_MEMTOREG` = 8, `CTRL_HILOTOREG` = 9.
  - Data field offsets for ALU result, read data, HI, LO and zero word.
- Sub-module: `sat_counter` (parameter `CNT_W`; ports `Clk`, `Rst`, `Inc`, `Count`) implements `StallCount`.
- All other logic is flat: state register, two payload registers and the output mux/mask.

## Test plan
- Reset then stream, with `OutReady` = 1 throughout:
  - Stimulus: push entries with `InData` = 1,2,3,4, one per cycle.
  - Required response: `OutData` shows 1,2,3,4 on consecutive cycles, each one cycle after its push. `StallCount` = 0.
- Backpressure with skid:
  - Stimulus: with M = 5 and `OutReady` = 0, push 6.
  - Required response: state goes FULL and `InReady` = 0.
  - Stimulus: hold `OutReady` = 0 for 3 cycles, then raise it.
  - Required response: `OutData` = 5, then 6. No entry is lost or duplicated. `StallCount` = 4.
- Flush with simultaneous push:
  - Stimulus: in FULL, or in ONE with `InValid` = 1, assert `Flush` for one cycle.
  - Required response: next cycle `OutValid` = 0, `OutCtrl` = 0 (RegWrite = 0), and the flushed-cycle input never appears.
- Mid-operation reset:
  - Stimulus: in FULL with `StallCount` = 7, assert `Rst` for one cycle.
  - Required response: all outputs return to their reset values and `StallCount` = 0. `InReady` = 0 during reset and 1 the cycle after.
- Counter saturation:
  - Stimulus: `CNT_W` = 3, `OutReady` = 0 for 10 cycles.
  - Required response: `StallCount` stops at 7.
- Random valid/ready:
  - Stimulus: random `InValid`/`OutReady` for 10,000 cycles, with a scoreboard comparing the output sequence to the input sequence.
  - Required response: exact order is preserved. `InReady` never depends combinationally on `OutReady`.

Source files
------------

// File: rtl/mem_wb_skid_stage_pkg.sv
// Shared definitions for the MEM->WB skid stage:
// occupancy encodings, control bit indices and data field offsets.
package mem_wb_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int CTRL_WADDR_LSB = 0;
  localparam int CTRL_WADDR_MSB = 3;
  localparam int CTRL_REGWRITE  = 4;
  localparam int CTRL_MOVNZ     = 5;
  localparam int CTRL_DONTMOVE  = 6;
  localparam int CTRL_HIORLO    = 7;
  localparam int CTRL_MEMTOREG  = 8;
  localparam int CTRL_HILOTOREG = 9;

  localparam int WORD_W     = 32;
  localparam int DATA_ALU   = 0;
  localparam int DATA_RDATA = 32;
  localparam int DATA_HI    = 64;
  localparam int DATA_LO    = 96;
  localparam int DATA_ZERO  = 128;

endpackage

// File: rtl/mem_wb_skid_stage_if.sv
// Valid/ready bundle between MEM (master side) and the skid stage,
// plus the stage's presentation towards WB.
interface mem_wb_skid_stage_if #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 10
);
  logic              InValid;
  logic              InReady;
  logic [CTRL_W-1:0] InCtrl;
  logic [DATA_W-1:0] InData;
  logic              Flush;
  logic              OutValid;
  logic              OutReady;
  logic [CTRL_W-1:0] OutCtrl;
  logic [DATA_W-1:0] OutData;

  modport master (
    output InValid, InCtrl, InData, Flush, OutReady,
    input  InReady, OutValid, OutCtrl, OutData
  );

  modport slave (
    input  InValid, InCtrl, InData, Flush, OutReady,
    output InReady, OutValid, OutCtrl, OutData
  );
endinterface

// File: rtl/mem_wb_skid_stage_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Inc,
  output logic [CNT_W-1:0] Count
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (Inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign Count = cnt_q;
endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB stage register with a 2-entry skid buffer, flush and
// a saturating stall counter. M drives the outputs, S is younger.
module mem_wb_skid_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  mem_wb_skid_stage_if.slave bus,
  output logic [CNT_W-1:0] StallCount
);
  logic [1:0]        state_q, state_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              push, pop;

  // Ready comes from registered state only, never from OutReady
  assign bus.InReady  = (state_q != ST_FULL) & ~Rst;
  assign bus.OutValid = (state_q != ST_EMPTY);
  assign push = bus.InValid & bus.InReady;
  assign pop  = bus.OutValid & bus.OutReady;

  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    if (bus.Flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d  = ST_ONE;
            m_ctrl_d = bus.InCtrl;
            m_data_d = bus.InData;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            m_ctrl_d = bus.InCtrl;
            m_data_d = bus.InData;
          end else if (push) begin
            state_d  = ST_FULL;
            s_ctrl_d = bus.InCtrl;
            s_data_d = bus.InData;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d  = ST_ONE;
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= ST_EMPTY;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
    end else begin
      state_q  <= state_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
    end
  end

  // Bubbles carry no control; data keeps its last value
  assign bus.OutCtrl = bus.OutValid ? m_ctrl_q : '0;
  assign bus.OutData = m_data_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .Inc   (bus.OutValid & ~bus.OutReady),
    .Count (StallCount)
  );
endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Randomized and directed bench for mem_wb_skid_stage against a
// queue-based reference model; a CNT_W=3 copy covers saturation.
module tb_mem_wb_skid_stage;
  import mem_wb_pkg::*;

  localparam int DW = 160;
  localparam int CW = 10;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic Clk = 0;
  logic Rst = 1;
  logic [15:0] cnt16;
  logic [2:0]  cnt3;

  int errs = 0;
  int checks = 0;

  ent_t mq[$];
  ent_t last;
  int   m16 = 0;
  int   m3 = 0;

  always #5 Clk = ~Clk;

  mem_wb_skid_stage_if #(.DATA_W(DW), .CTRL_W(CW)) b ();
  mem_wb_skid_stage_if #(.DATA_W(DW), .CTRL_W(CW)) b3 ();

  assign b3.InValid  = b.InValid;
  assign b3.InCtrl   = b.InCtrl;
  assign b3.InData   = b.InData;
  assign b3.Flush    = b.Flush;
  assign b3.OutReady = b.OutReady;

  mem_wb_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .bus(b.slave), .StallCount(cnt16)
  );

  mem_wb_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(3)) dut3 (
    .Clk(Clk), .Rst(Rst), .bus(b3.slave), .StallCount(cnt3)
  );

  function automatic logic [DW-1:0] rdata();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock edge; the model follows the FIFO rules of the stage
  task automatic tick();
    bit   push, pop, stall;
    ent_t e;
    int   n;
    n = mq.size();
    push = b.InValid && n < 2 && !Rst;
    pop = n > 0 && b.OutReady;
    stall = n > 0 && !b.OutReady;
    e.c = b.InCtrl;
    e.d = b.InData;
    @(posedge Clk);
    if (Rst) begin
      mq.delete();
      last.c = '0;
      last.d = '0;
      m16 = 0;
      m3 = 0;
    end else begin
      if (stall && m16 < 65535) m16++;
      if (stall && m3 < 7) m3++;
      if (b.Flush) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(e);
      end
      if (mq.size() > 0) last = mq[0];
    end
    #1;
  endtask

  task automatic drive(bit v, logic [DW-1:0] d, logic [CW-1:0] c,
                       bit r, bit f);
    b.InValid = v;
    b.InData = d;
    b.InCtrl = c;
    b.OutReady = r;
    b.Flush = f;
  endtask

  task automatic test_reset();
    drive(0, '0, '0, 1, 0);
    Rst = 1;
    tick();
    tick();
    checks++;
    if (b.OutValid !== 1'b0) begin
      errs++;
      $display("FAIL reset_outvalid got=%0b exp=0", b.OutValid);
    end
    checks++;
    if (b.OutCtrl !== '0 || b.OutData !== '0) begin
      errs++;
      $display("FAIL reset_out got ctrl=%h data=%h exp=0",
               b.OutCtrl, b.OutData);
    end
    checks++;
    if (b.InReady !== 1'b0) begin
      errs++;
      $display("FAIL reset_inready got=%0b exp=0", b.InReady);
    end
    checks++;
    if (cnt16 !== 16'd0 || cnt3 !== 3'd0) begin
      errs++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0", cnt16, cnt3);
    end
    Rst = 0;
    #1;
    checks++;
    if (b.InReady !== 1'b1) begin
      errs++;
      $display("FAIL reset_release_inready got=%0b exp=1", b.InReady);
    end
  endtask

  task automatic test_stream();
    logic [CW-1:0] c;
    for (int i = 1; i <= 4; i++) begin
      c = CW'($urandom);
      drive(1, DW'(i), c, 1, 0);
      tick();
      checks++;
      if (b.OutValid !== 1'b1 || b.OutData !== DW'(i) ||
          b.OutCtrl !== c) begin
        errs++;
        $display("FAIL stream_%0d got v=%0b d=%0d c=%h exp v=1 d=%0d c=%h",
                 i, b.OutValid, b.OutData, b.OutCtrl, i, c);
      end
    end
    drive(0, '0, '0, 1, 0);
    tick();
    checks++;
    if (b.OutValid !== 1'b0 || b.OutCtrl !== '0 ||
        b.OutData !== DW'(4)) begin
      errs++;
      $display("FAIL stream_drain got v=%0b c=%h d=%0d exp v=0 c=0 d=4",
               b.OutValid, b.OutCtrl, b.OutData);
    end
    checks++;
    if (cnt16 !== 16'd0) begin
      errs++;
      $display("FAIL stream_stall got=%0d exp=0", cnt16);
    end
  endtask

  task automatic test_backpressure();
    drive(1, DW'(5), CW'(1 << CTRL_REGWRITE), 1, 0);
    tick();
    drive(1, DW'(6), CW'(2), 0, 0);
    tick();
    checks++;
    if (b.InReady !== 1'b0 || b.OutData !== DW'(5)) begin
      errs++;
      $display("FAIL bp_full got rdy=%0b d=%0d exp rdy=0 d=5",
               b.InReady, b.OutData);
    end
    drive(1, DW'(99), CW'(3), 0, 0);
    tick();
    b.InValid = 0;
    tick();
    tick();
    checks++;
    if (cnt16 !== 16'd4 || b.OutData !== DW'(5)) begin
      errs++;
      $display("FAIL bp_stall got cnt=%0d d=%0d exp cnt=4 d=5",
               cnt16, b.OutData);
    end
    b.OutReady = 1;
    tick();
    checks++;
    if (b.OutValid !== 1'b1 || b.OutData !== DW'(6) ||
        b.InReady !== 1'b1) begin
      errs++;
      $display("FAIL bp_release got v=%0b d=%0d rdy=%0b exp v=1 d=6 rdy=1",
               b.OutValid, b.OutData, b.InReady);
    end
    tick();
    checks++;
    if (b.OutValid !== 1'b0 || cnt16 !== 16'd4) begin
      errs++;
      $display("FAIL bp_drain got v=%0b cnt=%0d exp v=0 cnt=4",
               b.OutValid, cnt16);
    end
  endtask

  task automatic test_flush();
    drive(1, DW'(7), CW'(5), 0, 0);
    tick();
    drive(1, DW'(8), CW'(6), 0, 0);
    tick();
    drive(1, DW'(9), CW'(1 << CTRL_REGWRITE), 1, 1);
    tick();
    checks++;
    if (b.OutValid !== 1'b0 || b.OutCtrl !== '0) begin
      errs++;
      $display("FAIL flush_full got v=%0b c=%h exp v=0 c=0",
               b.OutValid, b.OutCtrl);
    end
    drive(1, DW'(10), CW'(7), 0, 0);
    tick();
    drive(1, DW'(11), CW'(1 << CTRL_REGWRITE), 0, 1);
    tick();
    checks++;
    if (b.OutValid !== 1'b0 || b.OutCtrl[CTRL_REGWRITE] !== 1'b0) begin
      errs++;
      $display("FAIL flush_one got v=%0b c=%h exp v=0 c=0",
               b.OutValid, b.OutCtrl);
    end
    drive(0, '0, '0, 1, 0);
    tick();
    checks++;
    if (b.OutValid !== 1'b0 || b.OutData === DW'(11)) begin
      errs++;
      $display("FAIL flush_drop got v=%0b d=%0d exp v=0 d!=11",
               b.OutValid, b.OutData);
    end
  endtask

  task automatic test_saturate_and_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, rdata(), CW'($urandom), 0, 0);
      tick();
    end
    checks++;
    if (cnt3 !== 3'd7) begin
      errs++;
      $display("FAIL sat_cnt3 got=%0d exp=7", cnt3);
    end
    checks++;
    if (cnt16 !== 16'(m16)) begin
      errs++;
      $display("FAIL sat_cnt16 got=%0d exp=%0d", cnt16, m16);
    end
    checks++;
    if (b.InReady !== 1'b0 || b.OutValid !== 1'b1) begin
      errs++;
      $display("FAIL sat_full got rdy=%0b v=%0b exp rdy=0 v=1",
               b.InReady, b.OutValid);
    end
    Rst = 1;
    b.Flush = 1;
    tick();
    checks++;
    if (b.OutValid !== 1'b0 || b.OutCtrl !== '0 || b.OutData !== '0 ||
        b.InReady !== 1'b0 || cnt16 !== 16'd0 || cnt3 !== 3'd0) begin
      errs++;
      $display("FAIL midrst got v=%0b c=%h d=%h rdy=%0b cnt=%0d/%0d exp 0",
               b.OutValid, b.OutCtrl, b.OutData, b.InReady, cnt16, cnt3);
    end
    Rst = 0;
    drive(0, '0, '0, 1, 0);
    #1;
    checks++;
    if (b.InReady !== 1'b1) begin
      errs++;
      $display("FAIL midrst_release got rdy=%0b exp=1", b.InReady);
    end
  endtask

  task automatic test_random();
    ent_t     e;
    logic     r0;
    bit       hold;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    for (int i = 0; i < 10000; i++) begin
      hold = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 2) != 0, rdata(), CW'($urandom),
            hold ? 1'b0 : ($urandom_range(0, 1) == 1),
            $urandom_range(0, 63) == 0);
      if ((i % 16) == 0) begin
        #1;
        r0 = b.InReady;
        b.OutReady = ~b.OutReady;
        #1;
        checks++;
        if (b.InReady !== r0) begin
          errs++;
          $display("FAIL rand_ready_comb cyc=%0d got=%0b exp=%0b",
                   i, b.InReady, r0);
        end
        b.OutReady = ~b.OutReady;
      end
      tick();
      e = last;
      ec = (mq.size() > 0) ? e.c : '0;
      ed = e.d;
      checks++;
      if (b.OutValid !== (mq.size() > 0) || b.OutCtrl !== ec ||
          b.OutData !== ed) begin
        errs++;
        $display("FAIL rand_out cyc=%0d got v=%0b c=%h d=%h exp v=%0b c=%h d=%h",
                 i, b.OutValid, b.OutCtrl, b.OutData,
                 mq.size() > 0, ec, ed);
      end
      checks++;
      if (b.InReady !== (mq.size() < 2) || cnt16 !== 16'(m16) ||
          cnt3 !== 3'(m3)) begin
        errs++;
        $display("FAIL rand_ctl cyc=%0d got rdy=%0b cnt=%0d/%0d exp rdy=%0b cnt=%0d/%0d",
                 i, b.InReady, cnt16, cnt3, mq.size() < 2, m16, m3);
      end
    end
  endtask

  initial begin
    last.c = '0;
    last.d = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturate_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
